// File: rtl/lpc_autocorr.sv
// lpc_autocorr: streams one frame of signed samples, accumulates the
// autocorrelation lags R[0]..R[8] with one MAC per lag, then writes the nine
// saturated results into the LPC coefficient register file, one entry per
// cycle, through its one-hot wsel/din port.
module lpc_autocorr #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 64,
    parameter int SHIFT     = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [8:0]        wsel,
    output logic [31:0]       din,
    output logic              busy,
    output logic              done
);

    localparam int ACC_W = 2 * DATA_W + $clog2(FRAME_LEN);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(64'sd2147483647);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-64'sd2147483648);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_WRITE, S_DONE} state_t;

    state_t                    r_state, w_state_nxt;
    logic [3:0]                r_idx, w_idx_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [DATA_W-1:0]  r_dly [1:8];
    logic signed [ACC_W-1:0]   r_acc [0:8];
    logic signed [ACC_W-1:0]   w_acc_nxt [0:8];
    logic signed [DATA_W-1:0]  w_tap [0:8];
    logic signed [2*DATA_W-1:0] w_prod [0:8];
    logic signed [ACC_W-1:0]   w_acc_sel;
    logic signed [ACC_W-1:0]   w_acc_shf;
    logic [31:0]               w_din_sat;
    logic                      w_accept;
    logic [8:0]                r_wsel;
    logic [31:0]               r_din;
    logic                      r_busy;
    logic                      r_done;

    function automatic logic [31:0] sat32(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return 32'h7FFF_FFFF;
        else if (v < SAT_MIN) return 32'h8000_0000;
        else                  return v[31:0];
    endfunction

    assign in_ready = (r_state == S_ACC);
    assign w_accept = in_ready && in_valid;
    assign wsel     = r_wsel;
    assign din      = r_din;
    assign busy     = r_busy;
    assign done     = r_done;

    // Per-lag products of the incoming sample with the delay line, and the
    // accumulator values that the next edge will hold.
    always_comb begin
        w_tap[0] = in_data;
        for (int k = 1; k <= 8; k++) w_tap[k] = r_dly[k];
        for (int k = 0; k <= 8; k++) begin
            w_prod[k]    = (2*DATA_W)'(w_tap[0]) * (2*DATA_W)'(w_tap[k]);
            w_acc_nxt[k] = w_accept ? r_acc[k] + ACC_W'(w_prod[k]) : r_acc[k];
        end
        // Source lag for the upcoming write; taken from the post-update value
        // so the first write can follow the last accepted sample directly.
        w_acc_sel = w_acc_nxt[w_idx_nxt];
        w_acc_shf = w_acc_sel >>> SHIFT;
        w_din_sat = sat32(w_acc_shf);
    end

    // Next-state and write-index logic.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ACC;
            S_ACC: begin
                if (w_accept && (r_cnt == LAST_CNT)) begin
                    w_state_nxt = S_WRITE;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_WRITE: begin
                if (r_idx == 4'd8) w_state_nxt = S_DONE;
                else               w_idx_nxt   = r_idx + 4'd1;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and write-index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Delay line, accumulators and sample counter; cleared on start.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the delay line and accumulators are small register arrays, so they take the async reset like any flop.
        if (!reset_n) begin
            r_cnt <= '0;
            for (int k = 1; k <= 8; k++) r_dly[k] <= '0;
            for (int k = 0; k <= 8; k++) r_acc[k] <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_cnt <= '0;
            for (int k = 1; k <= 8; k++) r_dly[k] <= '0;
            for (int k = 0; k <= 8; k++) r_acc[k] <= '0;
        end else begin
            for (int k = 0; k <= 8; k++) r_acc[k] <= w_acc_nxt[k];
            if (w_accept) begin
                r_dly[1] <= in_data;
                for (int k = 2; k <= 8; k++) r_dly[k] <= r_dly[k-1];
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Registered outputs, derived from the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wsel <= '0;
            r_din  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_WRITE) begin
                r_wsel <= 9'd1 << w_idx_nxt;
                r_din  <= w_din_sat;
            end else begin
                r_wsel <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lpc_autocorr.sv
// tb_lpc_autocorr: three instances cover the short constant frame and the
// 64-sample frames with and without the output shift. Stimulus pushes the
// expected write sequence into a scoreboard queue; a negedge monitor pops
// and compares whenever an instance writes or signals done.
module tb_lpc_autocorr;

    typedef struct {
        int          dut;
        logic [8:0]  wsel;
        logic [31:0] din;
        logic        done;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               start    [3];
    logic signed [15:0] in_data  [3];
    logic               in_valid [3];
    logic               in_ready [3];
    logic [8:0]         wsel     [3];
    logic [31:0]        din      [3];
    logic               busy     [3];
    logic               done     [3];

    exp_t               sb_q[$];
    int                 checks = 0;
    int                 errors = 0;
    logic signed [15:0] smp [64];
    bit                 prev_last [3];
    logic [31:0]        r_exp [9];

    always #5 clk = ~clk;

    lpc_autocorr #(.DATA_W(16), .FRAME_LEN(4), .SHIFT(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .in_data(in_data[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .wsel(wsel[0]),
        .din(din[0]), .busy(busy[0]), .done(done[0]));

    lpc_autocorr #(.DATA_W(16), .FRAME_LEN(64), .SHIFT(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .in_data(in_data[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .wsel(wsel[1]),
        .din(din[1]), .busy(busy[1]), .done(done[1]));

    lpc_autocorr #(.DATA_W(16), .FRAME_LEN(64), .SHIFT(8)) dut_c (
        .clk(clk), .reset_n(reset_n), .start(start[2]), .in_data(in_data[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .wsel(wsel[2]),
        .din(din[2]), .busy(busy[2]), .done(done[2]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected lag for the alternating +/-32767 frame: (64-k) * 32767^2 with
    // sign (-1)^k, shifted and clamped to 32 bits.
    function automatic logic [31:0] exp_alt(input int k, input int sh);
        longint v;
        v = longint'(64 - k) * 64'sd1073676289;
        if (k % 2 == 1) v = -v;
        v = v >>> sh;
        if (v > 64'sd2147483647)       return 32'h7FFF_FFFF;
        else if (v < -64'sd2147483648) return 32'h8000_0000;
        else                           return v[31:0];
    endfunction

    task automatic push_frame(input int id, input logic [31:0] r [9]);
        exp_t e;
        for (int k = 0; k < 9; k++) begin
            e.dut = id; e.wsel = 9'd1 << k; e.din = r[k]; e.done = 1'b0;
            sb_q.push_back(e);
        end
        e.dut = id; e.wsel = 9'd0; e.din = 32'd0; e.done = 1'b1;
        sb_q.push_back(e);
    endtask

    // Drive one frame of smp[0..n-1]; optional random valid gaps, and with
    // poke set, stray starts and samples in ACC, WRITE and DONE.
    task automatic run_frame(input int id, input int n, input bit gaps, input bit poke);
        int k;
        int guard;
        bit acc;
        @(posedge clk); #1;
        in_valid[id] = 1'b1;
        in_data[id]  = 16'sh7abc;
        check("in_ready_idle", 64'(in_ready[id]), 64'd0);
        start[id] = 1'b1;
        @(posedge clk); #1;
        start[id] = 1'b0;
        check("busy_after_start", 64'(busy[id]), 64'd1);
        k = 0;
        guard = 0;
        while (k < n && guard < 2000) begin
            in_data[id]  = smp[k];
            in_valid[id] = gaps ? 1'($urandom_range(1)) : 1'b1;
            start[id]    = poke && (k == n / 2);
            acc = in_valid[id] && in_ready[id];
            @(posedge clk); #1;
            if (acc) k++;
            guard++;
        end
        start[id] = 1'b0;
        check("frame_accepted", 64'(k), 64'(n));
        if (poke) begin
            in_valid[id] = 1'b1;
            in_data[id]  = 16'sh7fff;
            start[id]    = 1'b1;
            check("in_ready_write", 64'(in_ready[id]), 64'd0);
            @(posedge clk); #1;
            start[id] = 1'b0;
        end else begin
            in_valid[id] = 1'b0;
        end
        guard = 0;
        while (!done[id] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("done_seen", 64'(done[id]), 64'd1);
        in_valid[id] = 1'b0;
        if (poke) start[id] = 1'b1;
        @(posedge clk); #1;
        start[id] = 1'b0;
        check("busy_after_done", 64'(busy[id]), 64'd0);
        check("done_one_cycle", 64'(done[id]), 64'd0);
    endtask

    // Scoreboard monitor: compare each write/done cycle against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) prev_last[i] = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (prev_last[i]) check("done_after_last", 64'(done[i]), 64'd1);
                prev_last[i] = (wsel[i] == 9'h100);
                if (wsel[i] != 9'd0 || done[i]) begin
                    check("wsel_onehot", 64'($onehot0(wsel[i])), 64'd1);
                    if (wsel[i] != 9'd0) check("in_ready_in_write", 64'(in_ready[i]), 64'd0);
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: dut %0d wsel %0h din %0h done %0b",
                                 i, wsel[i], din[i], done[i]);
                    end else begin
                        e = sb_q.pop_front();
                        check("dut_id", 64'(i), 64'(e.dut));
                        check("wsel", 64'(wsel[i]), 64'(e.wsel));
                        check("done", 64'(done[i]), 64'(e.done));
                        if (!e.done) check("din", 64'(din[i]), 64'(e.din));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0;
        end
        #2 reset_n = 1'b0;
        #10;
        for (int i = 0; i < 3; i++) begin
            check("rst_wsel", 64'(wsel[i]), 64'd0);
            check("rst_din", 64'(din[i]), 64'd0);
            check("rst_busy", 64'(busy[i]), 64'd0);
            check("rst_done", 64'(done[i]), 64'd0);
            check("rst_in_ready", 64'(in_ready[i]), 64'd0);
        end
        @(negedge clk) reset_n = 1'b1;

        // Constant frame of four 100s.
        for (int k = 0; k < 64; k++) smp[k] = 16'sd100;
        r_exp = '{32'd40000, 32'd30000, 32'd20000, 32'd10000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        push_frame(0, r_exp);
        run_frame(0, 4, 1'b0, 1'b0);

        // Impulse: 1000 then 63 zeros.
        for (int k = 0; k < 64; k++) smp[k] = 16'sd0;
        smp[0] = 16'sd1000;
        r_exp = '{32'd1000000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        push_frame(1, r_exp);
        run_frame(1, 64, 1'b0, 1'b0);

        // Alternating full-scale frame: every lag saturates.
        for (int k = 0; k < 64; k++) smp[k] = (k % 2 == 0) ? 16'sd32767 : -16'sd32767;
        for (int k = 0; k < 9; k++) r_exp[k] = (k % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        push_frame(1, r_exp);
        run_frame(1, 64, 1'b0, 1'b0);

        // Same frame with SHIFT = 8: unsaturated.
        r_exp[0] = 32'd268419072;
        for (int k = 1; k < 9; k++) r_exp[k] = exp_alt(k, 8);
        push_frame(2, r_exp);
        run_frame(2, 64, 1'b0, 1'b0);

        // Constant frame with random valid gaps and stray starts.
        for (int k = 0; k < 64; k++) smp[k] = 16'sd100;
        r_exp = '{32'd40000, 32'd30000, 32'd20000, 32'd10000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        push_frame(0, r_exp);
        run_frame(0, 4, 1'b1, 1'b1);

        // Async reset in the middle of the write phase.
        push_frame(0, r_exp);
        @(posedge clk); #1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0]    = 1'b0;
        in_valid[0] = 1'b1;
        in_data[0]  = 16'sd100;
        guard = 0;
        while (wsel[0] != 9'h008 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("wsel_before_reset", 64'(wsel[0]), 64'h008);
        reset_n = 1'b0;
        sb_q.delete();
        #1;
        check("abort_wsel", 64'(wsel[0]), 64'd0);
        check("abort_busy", 64'(busy[0]), 64'd0);
        check("abort_done", 64'(done[0]), 64'd0);
        check("abort_in_ready", 64'(in_ready[0]), 64'd0);
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        push_frame(0, r_exp);
        run_frame(0, 4, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpc_autocorr.md
Name: lpc_autocorr

Overview:
- Upstream producer for the 9-entry x 32-bit LPC coefficient register file.
- Accepts one frame of signed audio samples over a valid/ready stream.
- Computes autocorrelation lags R[0]..R[8] with one parallel MAC per lag.
- Writes the nine results into the register file, one per cycle, using the file's one-hot `wsel`/`din` write port, then pulses `done`.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- FRAME_LEN, 64, samples per frame (≥ 9).
- SHIFT, 0, arithmetic right shift applied to each accumulator before saturation to 32 bits.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a frame when idle.
- in_data  input  DATA_W  signed sample.
- in_valid  input  1  sample valid.
- in_ready  output  1  block accepts a sample this cycle.
- wsel  output  9  one-hot write select to the register file; 0 = no write.
- din  output  32  lag value for the selected entry.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last write.

Behaviour:
- Reset is asynchronous and active-low. While reset_n = 0:
  - state = IDLE; in_ready, wsel, din, busy and done = 0.
  - Delay line and all accumulators are cleared.
  - Reset asserted mid-frame or mid-write aborts immediately; wsel drops to 0 with no partial write cycle.
- All outputs are registered except in_ready, which is combinational from state (in_ready = 1 exactly in ACC).
- Accumulator width ACC_W = 2*DATA_W + clog2(FRAME_LEN), signed.
- States:
  - IDLE: on start = 1, clear the 8-deep delay line d[1..8] and acc[0..8] to 0, clear the sample counter, and go to ACC. start is ignored in every other state.
  - ACC: a sample is accepted on an edge where in_valid & in_ready.
    - On accept with x = in_data: acc[k] += x * d[k] for k = 0..8, where d[0] = x. Then shift d[8] <= d[7] ... d[1] <= x, and increment the counter.
    - Zero-initialised delay entries make terms with k > n contribute 0.
    - Gaps in in_valid stall with no state change.
    - When the FRAME_LEN-th sample is accepted, the next state is WRITE with index i = 0.
  - WRITE: one cycle per lag, i = 0..8.
    - wsel = 1 << i and din = sat32(acc[i] >>> SHIFT), both registered.
    - The first write cycle is the cycle immediately after the edge that accepted the last sample.
    - After i = 8, go to DONE.
  - DONE: wsel = 0, done = 1 for exactly one cycle, then return to IDLE.
- sat32 clamps to the range 0x80000000..0x7FFFFFFF.
- wsel is never multi-hot. It is 0 in every cycle outside WRITE.
- busy = 1 from the cycle after start is accepted through the DONE cycle inclusive.
- Accumulators hold their values after DONE until the next start.
- A start in the same cycle as DONE is ignored. A new frame needs start while in IDLE.

Test Plan:
- Constant frame, FRAME_LEN = 4, SHIFT = 0, samples 100,100,100,100 -> nine write cycles:
  - wsel 0x001..0x100 in order.
  - din = 40000, 30000, 20000, 10000, then 0 for lags 4..8.
  - done pulses once, the cycle after wsel = 0x100.
- Impulse, FRAME_LEN = 64: first sample 1000, then 63 zeros -> R0 = 1000000, R1..R8 = 0.
- Saturation, FRAME_LEN = 64, alternating +32767/−32767 -> R0 = 0x7FFFFFFF, R1 = 0x80000000, R2 = 0x7FFFFFFF.
- Rerun the saturation frame with SHIFT = 8 -> R0 = 64*1073676289 >> 8 = 268419072, unsaturated.
- Handshake: random in_valid gaps (~50%) over the constant frame -> identical din sequence to the gap-free run.
  - in_ready = 0 in IDLE and WRITE; samples presented then are not consumed.
  - start pulsed during ACC and WRITE is ignored (counter and results unchanged).
- Async reset: assert reset_n = 0 while wsel = 0x008 -> wsel = 0, busy = 0 and done = 0 without waiting for a clock edge.
  - After release, a fresh start with the constant frame reproduces the results from the first scenario.
